// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - LIFO stack with registered pop data, replace-top and sticky overflow/underflow flags
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         init,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] top_data;
    logic             do_push;
    logic             do_replace;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    // top_idx is garbage while empty; every consumer is gated on !empty
    assign top_idx  = AW'(count - CW'(1));
    assign wr_idx   = AW'(count);
    assign top_data = mem[top_idx];

    assign do_push    = !init && push && !pop && !full;
    assign do_replace = !init && push && pop && !empty;

    // Storage is deliberately not reset; the read below happens before the write lands
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end else if (do_replace) begin
            mem[top_idx] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (init) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (push && pop) begin
            dout_valid <= 1'b1;
            if (empty) begin
                dout <= din;
            end else begin
                dout <= top_data;
            end
        end else if (push) begin
            dout_valid <= 1'b0;
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                underflow  <= 1'b1;
                dout_valid <= 1'b0;
            end else begin
                dout       <= top_data;
                count      <= count - CW'(1);
                dout_valid <= 1'b1;
            end
        end else begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - scoreboard bench for lifo_stack against a queue-based reference stack
module tb_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             CLK;
    logic             RST_N;
    logic             init;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .init       (init),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: the stack is a queue, back = top
    logic [WIDTH-1:0] stk [$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;
    logic             m_ovf;
    logic             m_unf;
    logic [WIDTH-1:0] sbq [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_step(input logic i, input logic pu, input logic po, input logic [WIDTH-1:0] d);
        m_valid = 1'b0;
        if (i) begin
            model_reset();
        end else if (pu && po) begin
            m_valid = 1'b1;
            if (stk.size() == 0) begin
                m_dout = d;
            end else begin
                m_dout = stk[stk.size()-1];
                stk[stk.size()-1] = d;
            end
        end else if (pu) begin
            if (stk.size() == DEPTH) m_ovf = 1'b1;
            else stk.push_back(d);
        end else if (po) begin
            if (stk.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_dout  = stk.pop_back();
                m_valid = 1'b1;
            end
        end
        if (m_valid) sbq.push_back(m_dout);
    endtask

    task automatic check_state(input string tag);
        check({tag, " count"},      int'(count),      stk.size());
        check({tag, " empty"},      int'(empty),      int'(stk.size() == 0));
        check({tag, " full"},       int'(full),       int'(stk.size() == DEPTH));
        check({tag, " overflow"},   int'(overflow),   int'(m_ovf));
        check({tag, " underflow"},  int'(underflow),  int'(m_unf));
        check({tag, " dout"},       int'(dout),       int'(m_dout));
        check({tag, " dout_valid"}, int'(dout_valid), int'(m_valid));
    endtask

    // Called at a negedge; leaves the bench at the following negedge
    task automatic op(input string tag, input logic i, input logic pu, input logic po, input logic [WIDTH-1:0] d);
        init = i;
        push = pu;
        pop  = po;
        din  = d;
        @(posedge CLK);
        model_step(i, pu, po, d);
        @(negedge CLK);
        init = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        check_state(tag);
    endtask

    // Monitor: every dout_valid pulse must match the oldest expected pop result
    always @(negedge CLK) begin
        if (RST_N && dout_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got dout_valid=1 dout=0x%0h required no pulse", dout);
            end else begin
                check("sb_dout", int'(dout), int'(sbq.pop_front()));
            end
        end
    end

    initial begin
        RST_N = 1'b0;
        init  = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = '0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        op("idle", 0, 0, 0, 8'h00);

        op("push11", 0, 1, 0, 8'h11);
        op("push22", 0, 1, 0, 8'h22);
        op("push33", 0, 1, 0, 8'h33);
        op("push44", 0, 1, 0, 8'h44);
        op("push55_ovf", 0, 1, 0, 8'h55);
        for (int k = 0; k < 4; k++) op("pop4", 0, 0, 1, 8'h00);
        op("idle_after_pops", 0, 0, 0, 8'h00);

        op("pop_empty", 0, 0, 1, 8'h00);
        op("init", 1, 0, 0, 8'h00);

        op("pushA1", 0, 1, 0, 8'hA1);
        op("pushA2", 0, 1, 0, 8'hA2);
        op("replace_B0", 0, 1, 1, 8'hB0);
        op("pop_B0", 0, 0, 1, 8'h00);
        op("pop_A1", 0, 0, 1, 8'h00);

        op("passthru_5A", 0, 1, 1, 8'h5A);

        // Full-stack replace must not flag overflow
        for (int k = 0; k < 4; k++) op("fill", 0, 1, 0, 8'(8'hC0 + k));
        op("replace_full", 0, 1, 1, 8'hEE);
        op("init2", 1, 1, 1, 8'h77);

        op("push01", 0, 1, 0, 8'h01);
        op("push02", 0, 1, 0, 8'h02);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        check("async_rst count", int'(count), 0);
        check("async_rst dout", int'(dout), 0);
        check("async_rst dout_valid", int'(dout_valid), 0);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        op("push03", 0, 1, 0, 8'h03);
        op("pop03", 0, 0, 1, 8'h00);

        for (int n = 0; n < 400; n++) begin
            int r;
            logic i, pu, po;
            r  = $urandom_range(0, 99);
            i  = (r < 3);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            op("rand", i, pu, po, 8'($urandom));
        end

        @(negedge CLK);
        check("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal values are 1 and above.
REQ-002 Parameter DEPTH, default 256: entry count; legal values are 2 and above; need not be a power of 2.
REQ-003 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 init  input  1  synchronous clear of the stack; active-high.
REQ-006 push  input  1  write din onto the top of the stack.
REQ-007 pop  input  1  remove the top entry and present it on dout.
REQ-008 din  input  WIDTH  push data.
REQ-009 dout  output  WIDTH  registered pop data; holds its value until the next pop, pass-through or clear.
REQ-010 dout_valid  output  1  one-cycle pulse: dout was loaded at the last edge.
REQ-011 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-012 empty  output  1  combinational: count == 0.
REQ-013 full  output  1  combinational: count == DEPTH.
REQ-014 overflow  output  1  sticky flag: a push was rejected.
REQ-015 underflow  output  1  sticky flag: a pop was rejected.

Function
REQ-016 Each edge shall perform exactly one operation, in priority order: init, push&pop, push, pop, idle.
REQ-017 init shall set count=0, dout=0, dout_valid=0, overflow=0 and underflow=0; push and pop are ignored in that cycle.
REQ-018 push only, not full: mem[count]<=din, count<=count+1, dout unchanged, dout_valid<=0.
REQ-019 push only, full: count and memory unchanged; overflow<=1; dout_valid<=0.
REQ-020 pop only, not empty: dout<=mem[count-1], count<=count-1, dout_valid<=1; latency is one edge from the pop request to the data.
REQ-021 pop only, empty: count and dout unchanged; underflow<=1; dout_valid<=0.
REQ-022 push&pop, not empty (full included): dout<=old mem[count-1], mem[count-1]<=din, count unchanged, dout_valid<=1; this is a replace-top operation with no overflow.
REQ-023 push&pop, empty: pass-through; dout<=din, dout_valid<=1, count stays 0, no flag set.
REQ-024 Idle (no request): all registers hold; dout_valid<=0.
REQ-025 Once set, overflow and underflow shall stay set until init or reset.
REQ-026 count arithmetic shall never wrap: increments are blocked at DEPTH and decrements are blocked at 0 (REQ-019, REQ-021).
REQ-027 The memory array shall have no reset; the contents of unoccupied entries are don't-care and must never reach dout.
REQ-028 A read from an entry in the same cycle as its write (REQ-022) shall return the pre-write value.

Reset
REQ-029 RST_N low shall immediately, with no clock edge needed, force count=0, dout=0, dout_valid=0, overflow=0 and underflow=0.
REQ-030 Reset asserted mid-operation shall abandon any in-flight request; no memory write is guaranteed for that cycle.
REQ-031 The first operation after RST_N deasserts shall be honoured on the first rising edge with RST_N high.

Verification (WIDTH=8, DEPTH=4)
REQ-032 Reset then idle: count=0, empty=1, full=0, dout=0x00, dout_valid=0, flags 0.
REQ-033 Push 0x11, 0x22, 0x33, 0x44 -> full=1, count=4; then push 0x55 -> overflow=1, count=4; then pop x4 -> dout 0x44, 0x33, 0x22, 0x11, each with a dout_valid pulse; then empty=1.
REQ-034 Pop when empty -> underflow=1, dout unchanged, dout_valid=0; then init -> underflow=0, dout=0x00.
REQ-035 Push 0xA1, 0xA2, then push&pop with din=0xB0 -> dout=0xA2, count=2; then pop -> dout=0xB0.
REQ-036 Push&pop with din=0x5A while empty -> dout=0x5A, dout_valid=1, count=0, no flags set.
REQ-037 Push 0x01, 0x02, then assert RST_N low between edges -> count=0 and dout=0x00 immediately; then push 0x03 and pop after release -> dout=0x03.
